// File: rtl/mandel_engine.sv
// mandel_engine: one Mandelbrot iteration engine fed by the coordinate
// dispatcher. It takes a pixel job when idle and addressed, then iterates
// z = z^2 + c in Q8.24 at one step per clock until escape or MAX_ITER.
// The result is held on a valid/ready port until it is accepted.
module mandel_engine #(
  parameter int ENGINE_ID    = 0,
  parameter int C_ADDR_WIDTH = 4,
  parameter int MAX_ITER     = 255
) (
  input  logic                    cclk,
  input  logic                    creset,
  input  logic                    clatch_en,
  input  logic [C_ADDR_WIDTH-1:0] cengine_addr,
  input  logic [82:0]             cword2engines,
  output logic                    cdone,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [9:0]              res_x,
  output logic [8:0]              res_y,
  output logic [7:0]              res_iter
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic signed [31:0] FOUR = 32'sh0400_0000;

  logic [1:0]         state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic signed [31:0] cr_q, cr_d, ci_q, ci_d;
  logic signed [31:0] zr_q, zr_d, zi_q, zi_d;
  logic [7:0]         iter_q, iter_d;

  // Full-width signed products; the Q8.24 result is bits [55:24], which is
  // the same as an arithmetic shift by 24 truncated to 32 bits.
  logic signed [63:0] zr_w, zi_w, p_rr, p_ii, p_ri;
  logic signed [31:0] zr2, zi2, zri, mag2;
  logic               escape, at_limit, take_job;

  assign zr_w = 64'(zr_q);
  assign zi_w = 64'(zi_q);
  assign p_rr = zr_w * zr_w;
  assign p_ii = zi_w * zi_w;
  assign p_ri = zr_w * zi_w;
  assign zr2  = p_rr[55:24];
  assign zi2  = p_ii[55:24];
  assign zri  = p_ri[55:24];
  assign mag2 = zr2 + zi2;

  // Escape is strict: a magnitude of exactly 4.0 keeps iterating.
  assign escape   = mag2 > FOUR;
  assign at_limit = iter_q == 8'(MAX_ITER);
  assign take_job = clatch_en && (cengine_addr == C_ADDR_WIDTH'(ENGINE_ID));

  // Outputs come straight from state; z and iter freeze in HOLD, so the
  // held result is stable without a separate result register.
  assign cdone     = state_q == S_IDLE;
  assign res_valid = state_q == S_HOLD;
  assign res_x     = x_q;
  assign res_y     = y_q;
  assign res_iter  = iter_q;

  // Next-state: latch job in IDLE, iterate in CALC, wait for accept in HOLD.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (take_job) begin
          state_d = S_CALC;
          x_d     = cword2engines[82:73];
          y_d     = cword2engines[72:64];
          cr_d    = cword2engines[63:32];
          ci_d    = cword2engines[31:0];
          zr_d    = '0;
          zi_d    = '0;
          iter_d  = '0;
        end
      end
      S_CALC: begin
        // Test against the current z before updating, so every update
        // starts from |z| <= 2 and stays inside the Q8.24 range.
        if (escape || at_limit) begin
          state_d = S_HOLD;
        end else begin
          zr_d   = zr2 - zi2 + cr_q;
          zi_d   = (zri <<< 1) + ci_q;
          iter_d = iter_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight job and clears the result.
  always_ff @(posedge cclk or negedge creset) begin
    if (!creset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      zr_q    <= '0;
      zi_q    <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_mandel_engine.sv
// Bench for mandel_engine: directed corner cases plus random c values
// checked against a plain-arithmetic Mandelbrot reference.
module tb_mandel_engine;
  localparam int EID = 3;
  localparam int AW  = 4;
  localparam int MAXI = 255;

  logic          cclk = 1'b0;
  logic          creset = 1'b0;
  logic          clatch_en = 1'b0;
  logic [AW-1:0] cengine_addr = '0;
  logic [82:0]   cword2engines = '0;
  logic          cdone, res_valid;
  logic          res_ready = 1'b0;
  logic [9:0]    res_x;
  logic [8:0]    res_y;
  logic [7:0]    res_iter;

  int total = 0;
  int bad   = 0;

  mandel_engine #(.ENGINE_ID(EID), .C_ADDR_WIDTH(AW), .MAX_ITER(MAXI)) dut (
    .cclk(cclk), .creset(creset), .clatch_en(clatch_en),
    .cengine_addr(cengine_addr), .cword2engines(cword2engines),
    .cdone(cdone), .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_iter(res_iter));

  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  // Escape count of c: iterate z^2 + c with Q8.24 fixed point.
  function automatic int model(input int cr, input int ci);
    int zr = 0, zi = 0, a, b, c;
    for (int it = 0; it <= MAXI; it++) begin
      a = int'((longint'(zr) * longint'(zr)) >>> 24);
      b = int'((longint'(zi) * longint'(zi)) >>> 24);
      c = int'((longint'(zr) * longint'(zi)) >>> 24);
      if (a + b > 32'sh0400_0000 || it == MAXI) return it;
      zr = a - b + cr;
      zi = (c <<< 1) + ci;
    end
    return MAXI;
  endfunction

  task automatic drive_job(input logic [9:0] x, input logic [8:0] y,
                           input int cr, input int ci);
    clatch_en     = 1'b1;
    cengine_addr  = AW'(EID);
    cword2engines = {x, y, cr, ci};
  endtask

  // Latch a job at edge T0 and confirm the engine went busy.
  task automatic start_job(input string tag, input logic [9:0] x, input logic [8:0] y,
                           input int cr, input int ci);
    drive_job(x, y, cr, ci);
    tick();
    clatch_en = 1'b0;
    chk({tag, "_busy"}, 32'(cdone), 32'd0);
  endtask

  // k = edges already past T0; result must appear after edge T0+n+1.
  task automatic wait_result(input string tag, input int k0, input int n,
                             input logic [9:0] x, input logic [8:0] y);
    int k = k0;
    while (!res_valid && k < 400) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(n + 1));
    chk({tag, "_iter"}, 32'(res_iter), 32'(n));
    chk({tag, "_x"}, 32'(res_x), 32'(x));
    chk({tag, "_y"}, 32'(res_y), 32'(y));
  endtask

  task automatic accept(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_acc_v"}, 32'(res_valid), 32'd0);
    chk({tag, "_acc_idle"}, 32'(cdone), 32'd1);
  endtask

  task automatic job(input string tag, input logic [9:0] x, input logic [8:0] y,
                     input int cr, input int ci, input int n);
    start_job(tag, x, y, cr, ci);
    wait_result(tag, 0, n, x, y);
    accept(tag);
  endtask

  initial begin
    int cr, ci, n;
    logic [9:0] rx;
    logic [8:0] ry;
    logic [7:0] h_it;

    #12;
    chk("rst_cdone", 32'(cdone), 32'd1);
    chk("rst_valid", 32'(res_valid), 32'd0);
    creset = 1'b1;
    tick();

    // res_ready in IDLE is harmless.
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_ready", 32'(cdone), 32'd1);

    job("esc1",  10'd0,   9'd0,   32'hFE00_0000, 32'h0133_3333, 1);
    job("esc5",  10'd17,  9'd300, 32'h0080_0000, 32'h0,        5);
    job("c0",    10'd1023, 9'd511, 32'h0,        32'h0,        255);
    job("cm1",   10'd5,   9'd6,   32'hFF00_0000, 32'h0,        255);
    job("cm2",   10'd44,  9'd55,  32'hFE00_0000, 32'h0,        255);

    // Wrong address: nothing is latched.
    clatch_en     = 1'b1;
    cengine_addr  = AW'(EID + 1);
    cword2engines = {10'd9, 9'd9, 32'h0080_0000, 32'h0};
    tick();
    clatch_en = 1'b0;
    chk("miss_cdone", 32'(cdone), 32'd1);
    tick(); tick();
    chk("miss_valid", 32'(res_valid), 32'd0);

    // Second matching latch during CALC is ignored.
    start_job("dbl", 10'd7, 9'd8, 32'h0080_0000, 32'h0);
    tick();
    drive_job(10'd99, 9'd98, 32'h0, 32'h0);
    tick();
    clatch_en = 1'b0;
    wait_result("dbl", 2, 5, 10'd7, 9'd8);

    // Backpressure: result stays put for 10 cycles, then back-to-back job.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_cdone", 32'(cdone), 32'd0);
      chk("bp_res", {13'd0, res_x, res_y}, {13'd0, 10'd7, 9'd8});
      chk("bp_iter", 32'(res_iter), 32'd5);
    end
    accept("bp");
    start_job("b2b", 10'd300, 9'd200, 32'h0080_0000, 32'h0);
    wait_result("b2b", 0, 5, 10'd300, 9'd200);
    accept("b2b");

    // Asynchronous reset mid-CALC.
    start_job("rstm", 10'd123, 9'd45, 32'h0, 32'h0);
    tick(); tick(); tick();
    #2 creset = 1'b0;
    #1;
    chk("rstm_cdone", 32'(cdone), 32'd1);
    chk("rstm_valid", 32'(res_valid), 32'd0);
    chk("rstm_res", {5'd0, res_x, res_y, res_iter}, 32'd0);
    tick();
    creset = 1'b1;
    tick();
    chk("rstm_idle", 32'(cdone), 32'd1);
    job("post", 10'd2, 9'd3, 32'h0080_0000, 32'h0, 5);

    // Random c in [-2, 2) on both axes against the reference model.
    for (int t = 0; t < 24; t++) begin
      cr = int'($urandom_range(32'h03FF_FFFF, 0)) - 32'sh0200_0000;
      ci = int'($urandom_range(32'h03FF_FFFF, 0)) - 32'sh0200_0000;
      rx = 10'($urandom);
      ry = 9'($urandom);
      n  = model(cr, ci);
      start_job("rnd", rx, ry, cr, ci);
      wait_result("rnd", 0, n, rx, ry);
      h_it = res_iter;
      tick();
      chk("rnd_hold", 32'(res_iter), 32'(h_it));
      accept("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
